// File: rtl/ps2_scan_decoder_if.sv
// Connects the PS/2 receiver and the key-event consumer to the scan-code decoder.
// The master drives the receiver bytes and rd_en; the slave returns the head key event and FIFO status.
interface ps2_scan_decoder_if;
  logic [7:0] code;
  logic       tick;
  logic       correct;
  logic       rd_en;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_rel;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       frame_err;

  modport master (
    output code, tick, correct, rd_en,
    input  ev_code, ev_ext, ev_rel, empty, full, overflow, frame_err
  );

  modport slave (
    input  code, tick, correct, rd_en,
    output ev_code, ev_ext, ev_rel, empty, full, overflow, frame_err
  );
endinterface

// File: rtl/ps2_scan_decoder.sv
// Folds scan-code set 2 E0/F0 prefixes into {ext, rel, code} key events and
// queues them in a small first-word-fall-through FIFO for the consumer.
module ps2_scan_decoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input logic               clk,
  input logic               rst,
  ps2_scan_decoder_if.slave bus
);

  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_event_t;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t     state_q, state_d;
  logic       push_c;
  key_event_t push_ev_c;
  logic       good_c, bad_c, special_c;

  key_event_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_d;
  logic              empty_q, full_q, overflow_q, frame_err_q;
  logic              pop_c, wr_c, drop_c;

  assign good_c    = bus.tick & bus.correct;
  assign bad_c     = bus.tick & ~bus.correct;
  // Device responses and error codes never form a key event.
  assign special_c = (bus.code == 8'hAA) || (bus.code == 8'hFA) || (bus.code == 8'hEE) ||
                     (bus.code == 8'hFE) || (bus.code == 8'h00) || (bus.code == 8'hFF);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Prefix tracking and event generation.
  always_comb begin
    state_d        = state_q;
    push_c         = 1'b0;
    push_ev_c      = '0;
    push_ev_c.code = bus.code;
    if (bad_c) begin
      state_d = IDLE;
    end else if (good_c) begin
      if (special_c) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.code == 8'hE0)      state_d = EXT;
            else if (bus.code == 8'hF0) state_d = BRK;
            else                        push_c  = 1'b1;
          end
          EXT: begin
            if (bus.code == 8'hF0)      state_d = EXT_BRK;
            else if (bus.code != 8'hE0) begin
              push_c        = 1'b1;
              push_ev_c.ext = 1'b1;
              state_d       = IDLE;
            end
          end
          BRK: begin
            if (bus.code == 8'hE0)      state_d = EXT_BRK;
            else if (bus.code != 8'hF0) begin
              push_c        = 1'b1;
              push_ev_c.rel = 1'b1;
              state_d       = IDLE;
            end
          end
          EXT_BRK: begin
            if ((bus.code != 8'hE0) && (bus.code != 8'hF0)) begin
              push_c        = 1'b1;
              push_ev_c.ext = 1'b1;
              push_ev_c.rel = 1'b1;
              state_d       = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // A pop on a full FIFO frees the slot the push then lands in.
  assign pop_c   = bus.rd_en & ~empty_q;
  assign wr_c    = push_c & (~full_q | pop_c);
  assign drop_c  = push_c & full_q & ~pop_c;
  assign count_d = count + CW'(wr_c) - CW'(pop_c);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (wr_c) begin
        mem[wr_ptr] <= push_ev_c;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      count       <= count_d;
      empty_q     <= (count_d == CW'(0));
      full_q      <= (count_d == CW'(DEPTH));
      overflow_q  <= overflow_q | drop_c;
      frame_err_q <= bad_c;
    end
  end

  assign bus.ev_code   = mem[rd_ptr].code;
  assign bus.ev_ext    = mem[rd_ptr].ext;
  assign bus.ev_rel    = mem[rd_ptr].rel;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ps2_scan_decoder;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  ps2_scan_decoder_if bus ();

  ps2_scan_decoder #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: prefix flags and a queue of 10-bit events {ext, rel, code}.
  logic [9:0] mq[$];
  bit m_ext, m_rel, m_ovf, m_ferr, m_rst, m_valid = 1'b0;

  always @(posedge clk) begin
    bit         have;
    logic [9:0] ev;
    have = 1'b0;
    ev   = '0;
    if (!rst) begin
      mq.delete();
      m_ext = 0; m_rel = 0; m_ovf = 0; m_ferr = 0; m_rst = 1; m_valid = 1;
    end else if (m_valid) begin
      m_rst  = 0;
      m_ferr = bus.tick && !bus.correct;
      if (bus.tick) begin
        if (!bus.correct || bus.code inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
          m_ext = 0; m_rel = 0;
        end else if (bus.code == 8'hE0) begin
          m_ext = 1;
        end else if (bus.code == 8'hF0) begin
          m_rel = 1;
        end else begin
          ev   = {m_ext, m_rel, bus.code};
          have = 1'b1;
          m_ext = 0; m_rel = 0;
        end
      end
      if (bus.rd_en && mq.size() > 0) void'(mq.pop_front());
      if (have) begin
        if (mq.size() < DEPTH) mq.push_back(ev);
        else                   m_ovf = 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_empty",     32'(bus.empty),     32'(mq.size() == 0));
      chk("m_full",      32'(bus.full),      32'(mq.size() == DEPTH));
      chk("m_overflow",  32'(bus.overflow),  32'(m_ovf));
      chk("m_frame_err", 32'(bus.frame_err), 32'(m_ferr));
      if (mq.size() > 0)
        chk("m_head", 32'({bus.ev_ext, bus.ev_rel, bus.ev_code}), 32'(mq[0]));
      else if (m_rst)
        chk("m_rst_head", 32'({bus.ev_ext, bus.ev_rel, bus.ev_code}), 32'h0);
    end
  end

  task automatic send(input logic [7:0] b, input logic ok);
    @(posedge clk); #2;
    bus.tick = 1'b1; bus.code = b; bus.correct = ok;
    @(posedge clk); #2;
    bus.tick = 1'b0; bus.correct = 1'b0;
  endtask

  task automatic pop();
    @(posedge clk); #2;
    bus.rd_en = 1'b1;
    @(posedge clk); #2;
    bus.rd_en = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #2;
  endtask

  task automatic head(input string name, input logic e, input logic r, input logic [7:0] c);
    chk(name, 32'({bus.ev_ext, bus.ev_rel, bus.ev_code}), 32'({e, r, c}));
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    chk("rst_empty",    32'(bus.empty),     32'h1);
    chk("rst_full",     32'(bus.full),      32'h0);
    chk("rst_overflow", 32'(bus.overflow),  32'h0);
    chk("rst_ferr",     32'(bus.frame_err), 32'h0);
    head("rst_head", 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    bus.tick = 1'b0; bus.code = 8'h00; bus.correct = 1'b0; bus.rd_en = 1'b0;
    idle();
    do_reset();

    // Plain make code.
    send(8'h1C, 1'b1);
    chk("make_empty", 32'(bus.empty), 32'h0);
    head("make_head", 1'b0, 1'b0, 8'h1C);
    pop();
    chk("make_pop_empty", 32'(bus.empty), 32'h1);

    // Extended break.
    send(8'hE0, 1'b1);
    chk("e0_only_empty", 32'(bus.empty), 32'h1);
    send(8'hF0, 1'b1);
    chk("e0f0_empty", 32'(bus.empty), 32'h1);
    send(8'h75, 1'b1);
    head("extbrk_head", 1'b1, 1'b1, 8'h75);
    pop();
    chk("extbrk_single", 32'(bus.empty), 32'h1);

    // Parity error discards the prefix.
    send(8'hE0, 1'b1);
    send(8'h6B, 1'b0);
    chk("perr_pulse", 32'(bus.frame_err), 32'h1);
    chk("perr_nopush", 32'(bus.empty), 32'h1);
    idle();
    chk("perr_pulse_end", 32'(bus.frame_err), 32'h0);
    send(8'h6B, 1'b1);
    head("perr_after", 1'b0, 1'b0, 8'h6B);
    pop();

    // Device response clears prefix; F0 then E0 ordering tolerated.
    send(8'hE0, 1'b1);
    send(8'hAA, 1'b1);
    chk("aa_nopush", 32'(bus.empty), 32'h1);
    send(8'h34, 1'b1);
    head("aa_after", 1'b0, 1'b0, 8'h34);
    pop();
    send(8'hF0, 1'b1);
    send(8'hE0, 1'b1);
    send(8'h12, 1'b1);
    head("f0e0_head", 1'b1, 1'b1, 8'h12);
    pop();

    // Overflow.
    send(8'h15, 1'b1);
    send(8'h1D, 1'b1);
    send(8'h24, 1'b1);
    chk("ovf_not_full3", 32'(bus.full), 32'h0);
    send(8'h2D, 1'b1);
    chk("ovf_full4", 32'(bus.full), 32'h1);
    chk("ovf_clear4", 32'(bus.overflow), 32'h0);
    send(8'h2C, 1'b1);
    chk("ovf_set5", 32'(bus.overflow), 32'h1);
    head("ovf_rd0", 1'b0, 1'b0, 8'h15); pop();
    head("ovf_rd1", 1'b0, 1'b0, 8'h1D); pop();
    head("ovf_rd2", 1'b0, 1'b0, 8'h24); pop();
    head("ovf_rd3", 1'b0, 1'b0, 8'h2D); pop();
    chk("ovf_drained", 32'(bus.empty), 32'h1);
    chk("ovf_sticky", 32'(bus.overflow), 32'h1);

    // Full with simultaneous pop and push.
    do_reset();
    send(8'h15, 1'b1);
    send(8'h1D, 1'b1);
    send(8'h24, 1'b1);
    send(8'h2D, 1'b1);
    @(posedge clk); #2;
    bus.tick = 1'b1; bus.code = 8'h3C; bus.correct = 1'b1; bus.rd_en = 1'b1;
    @(posedge clk); #2;
    bus.tick = 1'b0; bus.correct = 1'b0; bus.rd_en = 1'b0;
    chk("sim_full", 32'(bus.full), 32'h1);
    chk("sim_noovf", 32'(bus.overflow), 32'h0);
    head("sim_rd0", 1'b0, 1'b0, 8'h1D); pop();
    head("sim_rd1", 1'b0, 1'b0, 8'h24); pop();
    head("sim_rd2", 1'b0, 1'b0, 8'h2D); pop();
    head("sim_rd3", 1'b0, 1'b0, 8'h3C); pop();
    chk("sim_drained", 32'(bus.empty), 32'h1);

    // Reset mid-sequence discards the prefix.
    send(8'hE0, 1'b1);
    send(8'hF0, 1'b1);
    do_reset();
    send(8'h29, 1'b1);
    head("midrst_head", 1'b0, 1'b0, 8'h29);
    chk("midrst_ovf", 32'(bus.overflow), 32'h0);
    pop();
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
- Sits directly downstream of the PS/2 receiver wrapper. It consumes the receiver's 8-bit code byte, its per-byte tick, and its frame-correct flag.
- It folds the scan-code set 2 prefixes (E0 extended, F0 break) into single key events of the form {extended, released, code}.
- Key events are buffered in a small FIFO for the consuming logic (game/display control), which reads with a simple rd_en handshake.

Parameters:
- DEPTH, 4: FIFO depth in entries. Must be a power of 2, at least 2.
- AW, 2: pointer width, equal to log2(DEPTH).

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-low reset. rst=0 at a rising clk edge resets the block.
- code, input, 8: byte from the receiver. Sampled only when tick=1.
- tick, input, 1: one-cycle pulse marking a new byte on code.
- correct, input, 1: frame parity/stop bit valid, qualified by tick.
- rd_en, input, 1: consumer pops the head entry. Ignored when empty=1.
- ev_code, output, 8: head entry's scan code.
- ev_ext, output, 1: head entry had the E0 prefix.
- ev_rel, output, 1: head entry had the F0 prefix (break/release).
- empty, output, 1: FIFO holds no entries.
- full, output, 1: FIFO holds DEPTH entries.
- overflow, output, 1: sticky flag; an event was dropped because the FIFO was full.
- frame_err, output, 1: one-cycle pulse when tick=1 and correct=0.

Behaviour:
- Reset (rst=0 at an edge):
  - FSM goes to IDLE.
  - Both pointers and the count are cleared to 0.
  - empty=1, full=0, overflow=0, frame_err=0.
  - ev_code=8'h00, ev_ext=0, ev_rel=0.
  - Reset applied mid-sequence (e.g. after E0) discards the partial prefix.
- Byte acceptance: only on tick=1. With tick=0 the FSM holds.
- Bad frame: tick=1 with correct=0 →
  - frame_err=1 on the next cycle;
  - FSM returns to IDLE, any prefix is discarded;
  - nothing is written.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). On a good byte b:
  - IDLE: b=E0 → EXT; b=F0 → BRK; otherwise push {0,0,b} and stay in IDLE.
  - EXT: b=F0 → EXT_BRK; b=E0 → stay in EXT; otherwise push {1,0,b} and go to IDLE.
  - BRK: b=E0 → EXT_BRK (tolerated ordering); b=F0 → stay in BRK; otherwise push {0,1,b} and go to IDLE.
  - EXT_BRK: b=E0 or b=F0 → stay in EXT_BRK; otherwise push {1,1,b} and go to IDLE.
  - Bytes AA, FA, EE, FE, 00, FF in any state: no push, FSM goes to IDLE. These are device responses or errors, not keys.
- Push latency: an event is written on the edge after its tick. empty falls one cycle after the final byte's tick.
- FIFO:
  - 10-bit entries {ext, rel, code}.
  - Output is first-word fall-through: ev_* always shows the head entry; ev_* is don't-care when empty=1.
  - rd_en with empty=0 advances the read pointer on the edge.
  - Pointers wrap modulo DEPTH.
  - The count is tracked with AW+1 bits; full = (count == DEPTH), empty = (count == 0).
- Simultaneous push and pop:
  - Not full: both happen; count unchanged.
  - Full: the pop frees a slot and the push is accepted; overflow is not set.
- Push while full with no pop: the event is dropped and overflow is set to 1.
- overflow clears only on reset.

Test Plan:
- Make code 1C (A): tick code=1C, correct=1 → one cycle later empty=0, ev_code=1C, ev_ext=0, ev_rel=0. Pulse rd_en → empty=1.
- Extended break: ticks E0, F0, 75 → exactly one entry {ev_ext=1, ev_rel=1, ev_code=75}; no entries after E0 or F0 alone.
- Parity error: tick E0 (good), then 6B with correct=0 → frame_err pulses for 1 cycle, no push. Then tick 6B good → entry {0,0,6B} (prefix was discarded).
- Overflow: push 5 make codes 15, 1D, 24, 2D, 2C with DEPTH=4 and no reads → full=1 after the 4th, overflow=1 after the 5th. Reads return 15, 1D, 24, 2D in order, then empty=1.
- Full with simultaneous rd_en and push of 3C → overflow stays 0, full stays 1, head advances to 1D, and 3C is read last.
- Reset mid-sequence: ticks E0, F0, then rst=0 for 1 cycle, then tick 29 → entry {0,0,29}; overflow=0, and all outputs hold their reset values during reset.
